// File: rtl/coproc_pkg.sv
// coproc_pkg: shared constants and clamp helper for the matrix coprocessor.
// State encodings and the signed 8-bit saturation limits live here.
package coproc_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  localparam logic signed [7:0] S8_MAX = 8'sd127;
  localparam logic signed [7:0] S8_MIN = 8'sh80;

  // Returns {sat_flag, clamped_value} for a 16-bit signed input.
  function automatic logic [8:0] clamp_s16(
    input logic signed [15:0] v
  );
    logic [8:0] r;
    if (v > 16'sd127)
      r = {1'b1, S8_MAX};
    else if (v < -16'sd128)
      r = {1'b1, S8_MIN};
    else
      r = {1'b0, v[7:0]};
    return r;
  endfunction

endpackage

// File: rtl/dot_acc8_sat_add8.sv
// dot_acc8_sat_add8: signed 8-bit add with clamp to [-128, 127].
// sat is high whenever the true sum fell outside the 8-bit range.
module sat_add8
  import coproc_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       sat
);

  logic signed [15:0] wide;

  // Sign-extend both operands, add exactly, then clamp.
  always_comb begin
    wide       = 16'($signed(a)) + 16'($signed(b));
    {sat, sum} = clamp_s16(wide);
  end

endmodule

// File: rtl/dot_acc8.sv
// dot_acc8: sums LEN signed products into a saturated 8-bit result.
// DOT_ACC8_WIDE_ACC_EN: 16-bit accumulate, clamp once at the end.
module dot_acc8
  import coproc_pkg::*;
#(
  parameter int LEN   = 4,
  parameter int CNT_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_prod,
  input  logic       in_ovf,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_sum,
  output logic       out_ovf,
  output logic       busy
);

  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             ovf_sticky;
  logic             ovf_base;
  logic             ovf_nxt;
  logic             accept;
  logic             drop;
  logic             last;
  logic             in_idle;
  logic             in_hold;
  logic [7:0]       fin_sum;
  logic             fin_sat;

`ifdef DOT_ACC8_WIDE_ACC_EN
  logic signed [15:0] acc;
  logic signed [15:0] acc_base;
  logic signed [15:0] acc_nxt;

  // Exact running sum; overflow only reflects multiplier flags here.
  always_comb begin
    acc_base = in_idle ? 16'sd0 : acc;
    acc_nxt  = acc_base + 16'($signed(in_prod));
    ovf_nxt  = ovf_base | in_ovf;
  end

  // One clamp on the final sum; acc is stable while holding.
  always_comb begin
    {fin_sat, fin_sum} = clamp_s16(acc);
  end
`else
  logic [7:0] acc;
  logic [7:0] acc_base;
  logic [7:0] acc_nxt;
  logic       add_sat;

  sat_add8 u_add (
    .a   (acc_base),
    .b   (in_prod),
    .sum (acc_nxt),
    .sat (add_sat)
  );

  // Per-step saturation; each clamp is folded into the sticky flag.
  always_comb begin
    acc_base = in_idle ? 8'd0 : acc;
    ovf_nxt  = ovf_base | in_ovf | add_sat;
    fin_sum  = acc;
    fin_sat  = 1'b0;
  end
`endif

  // Handshake and sequencing terms, decoded from state only.
  always_comb begin
    in_idle  = (state == ST_IDLE);
    in_hold  = (state == ST_HOLD);
    in_ready = (state == ST_IDLE) | (state == ST_ACC);
    busy     = !in_idle;
    accept   = in_valid & in_ready;
    drop     = out_valid & out_ready;
    ovf_base = in_idle ? 1'b0 : ovf_sticky;
    cnt_inc  = (in_idle ? '0 : cnt) + 1'b1;
    last     = (cnt_inc == LEN_C);
  end

  // Result is only driven while holding, zero otherwise.
  always_comb begin
    out_valid = in_hold;
    out_sum   = in_hold ? fin_sum : 8'd0;
    out_ovf   = in_hold & (ovf_sticky | fin_sat);
  end

  // Accumulate on accept, clear on drop or reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      acc        <= '0;
      ovf_sticky <= 1'b0;
      cnt        <= '0;
    end else begin
      unique case (1'b1)
        (state == ST_IDLE),
        (state == ST_ACC): begin
          if (accept) begin
            acc        <= acc_nxt;
            ovf_sticky <= ovf_nxt;
            cnt        <= cnt_inc;
            state      <= last ? ST_HOLD : ST_ACC;
          end
        end
        (state == ST_HOLD): begin
          if (drop) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
            cnt        <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dot_acc8.sv
// tb_dot_acc8: directed checks of the dot-product accumulator.
// Expected sums are hand-derived, step-wise saturated by default.
module tb_dot_acc8;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_prod;
  logic       in_ovf;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_ovf;
  logic       busy;

  int vecs;
  int errs;

  dot_acc8 #(.LEN(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_prod   (in_prod),
    .in_ovf    (in_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string      tag,
    input logic [7:0] obs,
    input logic [7:0] exp
  );
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] p, input logic o);
    in_valid = 1'b1;
    in_prod  = p;
    in_ovf   = o;
    chk("in_ready_pre", {7'd0, in_ready}, 8'd1);
    step();
    in_valid = 1'b0;
    in_ovf   = 1'b0;
  endtask

  task automatic result(
    input string      tag,
    input logic [7:0] s,
    input logic       o
  );
    chk({tag, "_valid"}, {7'd0, out_valid}, 8'd1);
    chk({tag, "_sum"}, out_sum, s);
    chk({tag, "_ovf"}, {7'd0, out_ovf}, {7'd0, o});
    chk({tag, "_rdy"}, {7'd0, in_ready}, 8'd0);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_dvalid"}, {7'd0, out_valid}, 8'd0);
    chk({tag, "_dbusy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_drdy"}, {7'd0, in_ready}, 8'd1);
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_prod   = 8'd0;
    in_ovf    = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_valid", {7'd0, out_valid}, 8'd0);
    chk("rst_sum", out_sum, 8'd0);
    chk("rst_ovf", {7'd0, out_ovf}, 8'd0);
    chk("rst_rdy", {7'd0, in_ready}, 8'd1);
    rst_n = 1'b1;
    step();

    // 10 + 20 - 5 + 3 = 28
    put(8'd10, 1'b0);
    chk("t1_busy", {7'd0, busy}, 8'd1);
    put(8'd20, 1'b0);
    put(8'hFB, 1'b0);
    chk("t1_early", {7'd0, out_valid}, 8'd0);
    put(8'd3, 1'b0);
    result("t1", 8'd28, 1'b0);
    drain("t1");

    // 100, 50 -> 127 (sat), -60 -> 67, 0 -> 67
    put(8'd100, 1'b0);
    put(8'd50, 1'b0);
    put(8'hC4, 1'b0);
    put(8'd0, 1'b0);
`ifdef DOT_ACC8_WIDE_ACC_EN
    result("t2", 8'd90, 1'b0);
`else
    result("t2", 8'd67, 1'b1);
`endif
    drain("t2");

    // -100, -200 -> -128 (sat), -118, -108
    put(8'h9C, 1'b0);
    put(8'h9C, 1'b0);
    put(8'd10, 1'b0);
    put(8'd10, 1'b0);
`ifdef DOT_ACC8_WIDE_ACC_EN
    result("t3", 8'h80, 1'b1);
`else
    result("t3", 8'h94, 1'b1);
`endif
    drain("t3");

    // Input overflow flag on the second product only
    put(8'd1, 1'b0);
    put(8'd1, 1'b1);
    put(8'd1, 1'b0);
    put(8'd1, 1'b0);
    result("t4", 8'd4, 1'b1);
    drain("t4");

    // Back-pressure in HOLD with a product waiting upstream
    put(8'd5, 1'b0);
    put(8'd5, 1'b0);
    put(8'd5, 1'b0);
    put(8'd5, 1'b0);
    in_valid = 1'b1;
    in_prod  = 8'h7F;
    in_ovf   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      result("t5_hold", 8'd20, 1'b0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t5_dvalid", {7'd0, out_valid}, 8'd0);
    chk("t5_dbusy", {7'd0, busy}, 8'd0);
    put(8'd7, 1'b0);
    put(8'd1, 1'b0);
    put(8'd1, 1'b0);
    put(8'd1, 1'b0);
    result("t5_next", 8'd10, 1'b0);
    drain("t5");

    // Reset after two accepts discards the partial sum
    put(8'd50, 1'b0);
    put(8'd50, 1'b1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t6_busy", {7'd0, busy}, 8'd0);
    chk("t6_valid", {7'd0, out_valid}, 8'd0);
    put(8'd1, 1'b0);
    put(8'd2, 1'b0);
    put(8'd3, 1'b0);
    put(8'd4, 1'b0);
    result("t6", 8'd10, 1'b0);

    // Reset while holding drops the result with no handshake
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t7_valid", {7'd0, out_valid}, 8'd0);
    chk("t7_sum", out_sum, 8'd0);
    chk("t7_rdy", {7'd0, in_ready}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
